// File: rtl/mod_148_4_4_beacon_monitor.sv
// PLCA beacon monitor: qualifies synchronised rx_beacon pulses by length against
// the 148.4.4 timer bank and tracks sync status toward the PLCA control diagram.
module mod_148_4_4_beacon_monitor #(
   parameter int unsigned MIN_BEACON_CYC = 4,
   parameter int unsigned INVALID_LIMIT  = 3,
   parameter int unsigned CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       plca_en,
   input  logic       rx_beacon,
   input  logic       beacon_det_timer_done,
   input  logic       invalid_beacon_timer_done,
   output logic       start_beacon_det_timer,
   output logic       start_invalid_beacon_timer,
   output logic       beacon_valid,
   output logic       beacon_invalid,
   output logic       plca_status,
   output logic [3:0] invalid_cnt
);

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      IDLE     = 2'd1,
      MEASURE  = 2'd2,
      HOLDOFF  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_BEACON_CYC);
   localparam logic [CNT_W-1:0] LEN_MAX = '1;
   localparam logic [3:0]       LIMIT   = 4'(INVALID_LIMIT);
   localparam logic [1:0]       BLANK   = 2'd2;

   state_t           state, state_nxt;
   logic             rx_s1, rx_s2, rx_d;
   logic             rx_rise;
   logic [CNT_W-1:0] len_cnt, len_nxt;
   logic [1:0]       det_blank, det_blank_nxt;
   logic [1:0]       inv_blank, inv_blank_nxt;
   logic             det_done_q, inv_done_q;
   logic             reject;
   logic [3:0]       cnt_inc, cnt_nxt;
   logic             status_nxt;
   logic             start_det_nxt, start_inv_nxt;
   logic             valid_nxt, invalid_nxt;

   // rx_d is the registered copy of the synchronised level, used only for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1 <= 1'b0;
         rx_s2 <= 1'b0;
         rx_d  <= 1'b0;
      end else begin
         rx_s1 <= rx_beacon;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   assign rx_rise    = rx_s2 & ~rx_d;
   assign det_done_q = beacon_det_timer_done && (det_blank == 2'd0);
   assign inv_done_q = invalid_beacon_timer_done && (inv_blank == 2'd0);
   assign cnt_inc    = (invalid_cnt == 4'hF) ? invalid_cnt : invalid_cnt + 4'd1;

   always_comb begin
      state_nxt     = state;
      len_nxt       = len_cnt;
      cnt_nxt       = invalid_cnt;
      status_nxt    = plca_status;
      start_det_nxt = 1'b0;
      start_inv_nxt = 1'b0;
      valid_nxt     = 1'b0;
      invalid_nxt   = 1'b0;
      reject        = 1'b0;
      det_blank_nxt = (det_blank == 2'd0) ? 2'd0 : det_blank - 2'd1;
      inv_blank_nxt = (inv_blank == 2'd0) ? 2'd0 : inv_blank - 2'd1;

      if (!plca_en) begin
         state_nxt  = DISABLED;
         status_nxt = 1'b0;
         cnt_nxt    = '0;
      end else begin
         case (state)
            DISABLED: begin
               state_nxt  = IDLE;
               status_nxt = 1'b0;
               cnt_nxt    = '0;
            end
            IDLE: begin
               if (rx_rise) begin
                  start_det_nxt = 1'b1;
                  det_blank_nxt = BLANK;
                  len_nxt       = CNT_W'(1);
                  state_nxt     = MEASURE;
               end
            end
            MEASURE: begin
               // the fall is checked before timer done so a same-cycle tie is judged by length
               if (!rx_s2) begin
                  if (len_cnt >= MIN_LEN) begin
                     valid_nxt  = 1'b1;
                     cnt_nxt    = '0;
                     status_nxt = 1'b1;
                     state_nxt  = IDLE;
                  end else begin
                     reject = 1'b1;
                  end
               end else if (det_done_q) begin
                  reject = 1'b1;
               end else if (len_cnt != LEN_MAX) begin
                  len_nxt = len_cnt + 1'b1;
               end
            end
            HOLDOFF: begin
               if (inv_done_q) state_nxt = IDLE;
            end
            default: state_nxt = DISABLED;
         endcase

         if (reject) begin
            invalid_nxt   = 1'b1;
            start_inv_nxt = 1'b1;
            inv_blank_nxt = BLANK;
            cnt_nxt       = cnt_inc;
            if (cnt_inc >= LIMIT) status_nxt = 1'b0;
            state_nxt     = HOLDOFF;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                      <= DISABLED;
         len_cnt                    <= '0;
         det_blank                  <= '0;
         inv_blank                  <= '0;
         invalid_cnt                <= '0;
         plca_status                <= 1'b0;
         start_beacon_det_timer     <= 1'b0;
         start_invalid_beacon_timer <= 1'b0;
         beacon_valid               <= 1'b0;
         beacon_invalid             <= 1'b0;
      end else begin
         state                      <= state_nxt;
         len_cnt                    <= len_nxt;
         det_blank                  <= det_blank_nxt;
         inv_blank                  <= inv_blank_nxt;
         invalid_cnt                <= cnt_nxt;
         plca_status                <= status_nxt;
         start_beacon_det_timer     <= start_det_nxt;
         start_invalid_beacon_timer <= start_inv_nxt;
         beacon_valid               <= valid_nxt;
         beacon_invalid             <= invalid_nxt;
      end
   end

endmodule

// File: tb/tb_mod_148_4_4_beacon_monitor.sv
// Directed bench for the beacon monitor: latencies, length limits, blanking, tie, abort, reset.
module tb_mod_148_4_4_beacon_monitor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       plca_en;
   logic       rx_beacon;
   logic       beacon_det_timer_done;
   logic       invalid_beacon_timer_done;
   logic       start_beacon_det_timer;
   logic       start_invalid_beacon_timer;
   logic       beacon_valid;
   logic       beacon_invalid;
   logic       plca_status;
   logic [3:0] invalid_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   mod_148_4_4_beacon_monitor #(
      .MIN_BEACON_CYC (4),
      .INVALID_LIMIT  (3),
      .CNT_W          (8)
   ) dut (
      .clk                        (clk),
      .rst_n                      (rst_n),
      .plca_en                    (plca_en),
      .rx_beacon                  (rx_beacon),
      .beacon_det_timer_done      (beacon_det_timer_done),
      .invalid_beacon_timer_done  (invalid_beacon_timer_done),
      .start_beacon_det_timer     (start_beacon_det_timer),
      .start_invalid_beacon_timer (start_invalid_beacon_timer),
      .beacon_valid               (beacon_valid),
      .beacon_invalid             (beacon_invalid),
      .plca_status                (plca_status),
      .invalid_cnt                (invalid_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_start_det"}, start_beacon_det_timer, 1'b0);
      check({tag, "_start_inv"}, start_invalid_beacon_timer, 1'b0);
      check({tag, "_valid"}, beacon_valid, 1'b0);
      check({tag, "_invalid"}, beacon_invalid, 1'b0);
      check({tag, "_status"}, plca_status, 1'b0);
      check({tag, "_cnt"}, invalid_cnt, 4'd0);
   endtask

   // rx_beacon high for len clocks (len >= 4), expected to qualify
   task automatic run_valid(input int len);
      rx_beacon = 1'b1;
      tick(); tick();
      check("v_start_early", start_beacon_det_timer, 1'b0);
      tick();
      check("v_start_3clk", start_beacon_det_timer, 1'b1);
      tick();
      check("v_start_1wide", start_beacon_det_timer, 1'b0);
      repeat (len - 4) tick();
      rx_beacon = 1'b0;
      tick(); tick();
      check("v_valid_early", beacon_valid, 1'b0);
      tick();
      check("v_valid", beacon_valid, 1'b1);
      check("v_no_invalid", beacon_invalid, 1'b0);
      check("v_status", plca_status, 1'b1);
      check("v_cnt", invalid_cnt, 4'd0);
      tick();
      check("v_valid_1wide", beacon_valid, 1'b0);
   endtask

   // rx_beacon high 2 clocks; returns in the cycle of the invalid pulse
   task automatic run_short(input logic [3:0] exp_cnt, input logic exp_status);
      rx_beacon = 1'b1;
      tick(); tick();
      rx_beacon = 1'b0;
      tick();
      check("s_start", start_beacon_det_timer, 1'b1);
      tick();
      check("s_invalid_early", beacon_invalid, 1'b0);
      tick();
      check("s_invalid", beacon_invalid, 1'b1);
      check("s_start_inv", start_invalid_beacon_timer, 1'b1);
      check("s_no_valid", beacon_valid, 1'b0);
      check("s_cnt", invalid_cnt, exp_cnt);
      check("s_status", plca_status, exp_status);
   endtask

   task automatic leave_holdoff();
      tick();
      check("h_invalid_1wide", beacon_invalid, 1'b0);
      check("h_start_inv_1wide", start_invalid_beacon_timer, 1'b0);
      tick(); tick();
      invalid_beacon_timer_done = 1'b1;
      tick();
      invalid_beacon_timer_done = 1'b0;
   endtask

   // held until det timer done; done raised in the strobe cycle so blanking is exercised too
   task automatic run_long(input logic [3:0] exp_cnt, input logic exp_status);
      rx_beacon = 1'b1;
      tick(); tick(); tick();
      check("l_start", start_beacon_det_timer, 1'b1);
      beacon_det_timer_done = 1'b1;
      tick();
      check("l_blank0", beacon_invalid, 1'b0);
      tick();
      check("l_blank1", beacon_invalid, 1'b0);
      tick();
      check("l_invalid", beacon_invalid, 1'b1);
      check("l_start_inv", start_invalid_beacon_timer, 1'b1);
      check("l_cnt", invalid_cnt, exp_cnt);
      check("l_status", plca_status, exp_status);
      beacon_det_timer_done = 1'b0;
      rx_beacon = 1'b0;
      leave_holdoff();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, n_checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      plca_en = 1'b1;
      rx_beacon = 1'b0;
      beacon_det_timer_done = 1'b0;
      invalid_beacon_timer_done = 1'b0;
      repeat (3) tick();
      check_all_zero("rst");
      rst_n = 1'b1;
      tick(); tick();

      run_valid(20);

      run_short(4'd1, 1'b1);
      tick();
      check("short_pulse_drop", beacon_invalid, 1'b0);
      rx_beacon = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("holdoff_ignore", start_beacon_det_timer, 1'b0);
      end
      rx_beacon = 1'b0;
      repeat (3) tick();
      invalid_beacon_timer_done = 1'b1;
      tick();
      invalid_beacon_timer_done = 1'b0;

      run_valid(4);

      run_long(4'd1, 1'b1);
      run_long(4'd2, 1'b1);
      run_long(4'd3, 1'b0);

      // tie: blanked done, then fall and done together with length 10
      rx_beacon = 1'b1;
      tick(); tick(); tick();
      check("t_start", start_beacon_det_timer, 1'b1);
      beacon_det_timer_done = 1'b1;
      tick();
      check("t_blank0", beacon_invalid, 1'b0);
      tick();
      check("t_blank1", beacon_invalid, 1'b0);
      beacon_det_timer_done = 1'b0;
      repeat (5) tick();
      rx_beacon = 1'b0;
      tick(); tick();
      beacon_det_timer_done = 1'b1;
      tick();
      check("t_valid", beacon_valid, 1'b1);
      check("t_no_invalid", beacon_invalid, 1'b0);
      check("t_status", plca_status, 1'b1);
      check("t_cnt", invalid_cnt, 4'd0);
      beacon_det_timer_done = 1'b0;
      tick();

      run_short(4'd1, 1'b1);
      leave_holdoff();

      // abort mid-MEASURE
      rx_beacon = 1'b1;
      tick(); tick(); tick();
      check("a_start", start_beacon_det_timer, 1'b1);
      tick(); tick();
      plca_en = 1'b0;
      tick();
      check_all_zero("abort");
      rx_beacon = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abort_no_valid", beacon_valid, 1'b0);
         check("abort_no_invalid", beacon_invalid, 1'b0);
      end

      // async reset in the first HOLDOFF cycle, while both invalid pulses are high
      plca_en = 1'b1;
      tick();
      run_short(4'd1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      tick();
      rst_n = 1'b1;
      tick();
      run_valid(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
